// File: rtl/relu_pool1.sv
// relu_pool1: ReLU followed by 2x2/stride-2 max pooling over a float8 map.
// Pooling windows are visited row-major, one per enabled cycle. The path has
// two stages: S1 holds the pair maxima, and S2 merges them into tensor_out.
module relu_pool1 #(
   parameter int IN_DIM  = 24,
   parameter int OUT_DIM = IN_DIM / 2
) (
   input  logic                          clk,
   input  logic                          iRst,
   input  logic                          ena,
   input  logic                          start,
   input  logic [IN_DIM*IN_DIM*8-1:0]    tensor_in,
   output logic [OUT_DIM*OUT_DIM*8-1:0]  tensor_out,
   output logic                          busy,
   output logic                          done
);

   localparam int IN_W   = IN_DIM * IN_DIM * 8;
   localparam int OUT_W  = OUT_DIM * OUT_DIM * 8;
   localparam int IN_IW  = $clog2(IN_W);
   localparam int OUT_IW = $clog2(OUT_W);
   localparam int K_W    = $clog2(OUT_DIM * OUT_DIM);
   localparam int CNT_W  = 4;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_DIM - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Negative bytes, including -0, clamp to +0. Otherwise the byte passes through.
   function automatic logic [7:0] relu8(input logic [7:0] v);
      return v[7] ? 8'h00 : v;
   endfunction

   // The operands are already non-negative, so the magnitude bits decide the result.
   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a[6:0] >= b[6:0]) ? a : b;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             s1_valid_q, s1_valid_d;
   logic [7:0]       s1_top_q, s1_top_d;
   logic [7:0]       s1_bot_q, s1_bot_d;
   logic [K_W-1:0]   s1_idx_q, s1_idx_d;
   logic [OUT_W-1:0] out_q, out_d;

   logic [IN_IW-1:0]  top_base, bot_base;
   logic [15:0]       top_pair, bot_pair;
   logic [K_W-1:0]    win_idx;
   logic [OUT_IW-1:0] wr_base;

   // Select the two input row pairs of the window named by the counters.
   always_comb begin
      top_base = IN_IW'(((2 * int'(row_cnt_q)) * IN_DIM + 2 * int'(col_cnt_q)) * 8);
      bot_base = IN_IW'(((2 * int'(row_cnt_q) + 1) * IN_DIM + 2 * int'(col_cnt_q)) * 8);
      top_pair = tensor_in[top_base +: 16];
      bot_pair = tensor_in[bot_base +: 16];
      win_idx  = K_W'(int'(row_cnt_q) * OUT_DIM + int'(col_cnt_q));
      wr_base  = OUT_IW'(int'(s1_idx_q) * 8);
   end

   // Next state for the FSM, the window counters and both pipeline stages.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      col_cnt_d  = col_cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      s1_valid_d = 1'b0;
      s1_top_d   = s1_top_q;
      s1_bot_d   = s1_bot_q;
      s1_idx_d   = s1_idx_q;
      out_d      = out_q;

      // S2 overwrites one byte of the result map. All other bytes hold.
      if (s1_valid_q) begin
         out_d[wr_base +: 8] = max8(s1_top_q, s1_bot_q);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               row_cnt_d = '0;
               col_cnt_d = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
            end
         end
         ST_RUN: begin
            s1_valid_d = 1'b1;
            s1_top_d   = max8(relu8(top_pair[7:0]), relu8(top_pair[15:8]));
            s1_bot_d   = max8(relu8(bot_pair[7:0]), relu8(bot_pair[15:8]));
            s1_idx_d   = win_idx;
            if (row_cnt_q == LAST && col_cnt_q == LAST) begin
               state_d = ST_DRAIN;
            end else if (col_cnt_q == LAST) begin
               col_cnt_d = '0;
               row_cnt_d = row_cnt_q + 1'b1;
            end else begin
               col_cnt_d = col_cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // The only window still in S1 here is the last one, and it is written on this edge.
            if (s1_valid_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State update. Reset takes priority, and ena gates everything else.
   always_ff @(posedge clk) begin
      if (iRst) begin
         // NOTE: the output map is a register bank, not a RAM, so it can be cleared in one edge like any other flop.
         state_q    <= ST_IDLE;
         row_cnt_q  <= '0;
         col_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_top_q   <= '0;
         s1_bot_q   <= '0;
         s1_idx_q   <= '0;
         out_q      <= '0;
      end else if (ena) begin
         // NOTE: non-blocking assignments, so every register updates from values sampled before the edge.
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         col_cnt_q  <= col_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         s1_valid_q <= s1_valid_d;
         s1_top_q   <= s1_top_d;
         s1_bot_q   <= s1_bot_d;
         s1_idx_q   <= s1_idx_d;
         out_q      <= out_d;
      end
   end

   assign tensor_out = out_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_relu_pool1.sv
// tb_relu_pool1: directed-sequence bench for relu_pool1, with random maps
// checked against a plain array model of ReLU followed by 2x2 max pooling.
module tb_relu_pool1;

   localparam int IN_DIM  = 24;
   localparam int OUT_DIM = 12;
   localparam int IN_W    = IN_DIM * IN_DIM * 8;
   localparam int OUT_W   = OUT_DIM * OUT_DIM * 8;

   logic             clk = 1'b0;
   logic             iRst = 1'b1;
   logic             ena = 1'b1;
   logic             start = 1'b0;
   logic [IN_W-1:0]  tensor_in = '0;
   logic [OUT_W-1:0] tensor_out;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   logic [7:0] in_mem [IN_DIM*IN_DIM];

   relu_pool1 #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) dut (
      .clk        (clk),
      .iRst       (iRst),
      .ena        (ena),
      .start      (start),
      .tensor_in  (tensor_in),
      .tensor_out (tensor_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_map(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: clamp negatives to zero, then take the largest of the four values in each window.
   function automatic logic [OUT_W-1:0] golden();
      logic [OUT_W-1:0] res;
      res = '0;
      for (int r = 0; r < OUT_DIM; r++) begin
         for (int c = 0; c < OUT_DIM; c++) begin
            int m;
            m = 0;
            for (int dr = 0; dr < 2; dr++) begin
               for (int dc = 0; dc < 2; dc++) begin
                  int v;
                  v = int'(in_mem[(2 * r + dr) * IN_DIM + 2 * c + dc]);
                  if (v < 128 && v > m) m = v;
               end
            end
            res[(r * OUT_DIM + c) * 8 +: 8] = 8'(m);
         end
      end
      return res;
   endfunction

   task automatic apply_map();
      for (int i = 0; i < IN_DIM * IN_DIM; i++) tensor_in[i * 8 +: 8] = in_mem[i];
   endtask

   task automatic random_map();
      for (int i = 0; i < IN_DIM * IN_DIM; i++) in_mem[i] = 8'($urandom_range(0, 255));
      apply_map();
   endtask

   // Pulse start (edge 0), then count cycles until done. lat is -1 if the budget runs out.
   task automatic run_wait(input bit stall, input bit busy_start, output int lat, output logic [7:0] pre_last);
      int cyc;
      lat = -1;
      pre_last = 8'h00;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_v("busy_after_start", 32'(busy), 32'd1);
      check_v("done_after_start", 32'(done), 32'd0);
      cyc = 0;
      while (cyc < 400 && lat < 0) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (stall) begin
            if (cyc == 60) ena = 1'b0;
            if (cyc == 63) start = 1'b1;
            if (cyc == 64) start = 1'b0;
            if (cyc == 70) ena = 1'b1;
         end
         if (busy_start && cyc == 30) start = 1'b1;
         if (busy_start && cyc == 31) start = 1'b0;
         if (cyc == 144) pre_last = tensor_out[143 * 8 +: 8];
         if (done === 1'b1) begin
            lat = cyc;
            check_v("busy_at_done", 32'(busy), 32'd0);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      iRst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      iRst = 1'b0;
   endtask

   initial begin
      int lat;
      logic [7:0] pre_last;
      logic [OUT_W-1:0] zero_map;
      logic [OUT_W-1:0] exp_map;
      bit idle_ok;
      zero_map = '0;

      // Reset with a random map on the input.
      random_map();
      do_reset();
      check_v("rst_busy", 32'(busy), 32'd0);
      check_v("rst_done", 32'(done), 32'd0);
      check_map("rst_out", tensor_out, zero_map);
      idle_ok = 1'b1;
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || tensor_out !== zero_map) idle_ok = 1'b0;
      end
      check_v("idle_20_stable", 32'(idle_ok), 32'd1);

      // A start pulse while ena is low must not be sampled.
      ena = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      ena = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_v("start_ena0_ignored", 32'(busy), 32'd0);

      // Ramp map.
      for (int r = 0; r < IN_DIM; r++)
         for (int c = 0; c < IN_DIM; c++)
            in_mem[r * IN_DIM + c] = 8'(1 + ((r * IN_DIM + c) % 126));
      apply_map();
      run_wait(1'b0, 1'b0, lat, pre_last);
      check_v("ramp_latency", 32'(lat), 32'd145);
      check_map("ramp_map", tensor_out, golden());
      check_v("ramp_out00", 32'(tensor_out[7:0]), 32'h1A);

      // Ramp again from DONE, with a start pulse while busy that must be ignored.
      run_wait(1'b0, 1'b1, lat, pre_last);
      check_v("busy_start_latency", 32'(lat), 32'd145);
      check_map("busy_start_map", tensor_out, golden());

      // ReLU and sign handling.
      for (int i = 0; i < IN_DIM * IN_DIM; i++) in_mem[i] = 8'h85;
      in_mem[1] = 8'h80;
      in_mem[IN_DIM + 1] = 8'h03;
      apply_map();
      run_wait(1'b0, 1'b0, lat, pre_last);
      exp_map = '0;
      exp_map[7:0] = 8'h03;
      check_v("relu_latency", 32'(lat), 32'd145);
      check_map("relu_map", tensor_out, exp_map);

      for (int i = 0; i < IN_DIM * IN_DIM; i++) in_mem[i] = 8'hFF;
      apply_map();
      run_wait(1'b0, 1'b0, lat, pre_last);
      check_map("all_neg_map", tensor_out, zero_map);

      // Max ordering in the final window. Reset first so the final byte starts from 0.
      do_reset();
      random_map();
      in_mem[22 * IN_DIM + 22] = 8'h7F;
      in_mem[22 * IN_DIM + 23] = 8'h40;
      in_mem[23 * IN_DIM + 22] = 8'h7E;
      in_mem[23 * IN_DIM + 23] = 8'h00;
      apply_map();
      run_wait(1'b0, 1'b0, lat, pre_last);
      check_v("last_before_edge145", 32'(pre_last), 32'h00);
      check_v("last_latency", 32'(lat), 32'd145);
      check_v("last_out", 32'(tensor_out[143 * 8 +: 8]), 32'h7F);
      check_map("last_map", tensor_out, golden());

      // Enable stall of 10 cycles, with a start pulse inside the stall.
      random_map();
      run_wait(1'b1, 1'b0, lat, pre_last);
      check_v("stall_latency", 32'(lat), 32'd155);
      check_map("stall_map", tensor_out, golden());

      // Reset mid-run while ena is also low.
      random_map();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (70) @(posedge clk);
      @(negedge clk);
      check_v("midrun_busy_before", 32'(busy), 32'd1);
      iRst = 1'b1;
      ena = 1'b0;
      @(posedge clk);
      @(negedge clk);
      iRst = 1'b0;
      ena = 1'b1;
      check_map("midrun_rst_out", tensor_out, zero_map);
      check_v("midrun_rst_busy", 32'(busy), 32'd0);
      check_v("midrun_rst_done", 32'(done), 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_v("midrun_stays_idle", 32'(busy), 32'd0);

      // Full run, then a restart from DONE with a new map.
      random_map();
      run_wait(1'b0, 1'b0, lat, pre_last);
      check_map("first_map", tensor_out, golden());
      random_map();
      run_wait(1'b0, 1'b0, lat, pre_last);
      check_v("restart_latency", 32'(lat), 32'd145);
      check_map("restart_map", tensor_out, golden());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/relu_pool1.md
# relu_pool1

Post-processing stage directly downstream of the first convolution layer: applies ReLU and 2×2/stride-2 max pooling to the 24×24 float8 feature map produced by the convolution, yielding a 12×12 float8 map for the next layer. It walks the 144 pooling windows sequentially, one window per enabled cycle, through a two-stage pipeline, and signals completion with a level `done`.

## Interface
Parameters:
- `IN_DIM`, 24, input map side (must be even)
- `OUT_DIM`, 12, output map side, fixed at `IN_DIM/2`

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `iRst`  in  1  synchronous, active-high reset
- `ena`  in  1  clock enable; low = every register holds, including the FSM and pipeline
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE with `ena`=1
- `tensor_in`  in  `IN_DIM*IN_DIM*8`  float8 map; element (r,c) at bits `(r*IN_DIM+c)*8 +: 8`; must be held stable while `busy`=1
- `tensor_out`  out  `OUT_DIM*OUT_DIM*8`  pooled map; element (r,c) at bits `(r*OUT_DIM+c)*8 +: 8`
- `busy`  out  1  high from the `start` edge until the last write
- `done`  out  1  level; high once the full map is written, until the next `start` or reset

## Operation
- Float8 is sign-magnitude: bit 7 = sign, bits [6:0] = exponent|mantissa, monotonic as unsigned.
- ReLU: any byte with bit 7 = 1 (including −0, 0x80) becomes 0x00; otherwise it passes unchanged.
- After ReLU, max = unsigned compare of bits [6:0]. Ties take either operand; the bit pattern is identical either way.
- Window (r,c), with r,c in 0..11, covers inputs (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1). Its result is written to output index r*12+c.
- Window order is row-major: k = r*12+c, k = 0..143. Counters are `rowCnt` and `colCnt`, 4 bits each. `colCnt` wraps 11→0 and increments `rowCnt`.
- Pipeline:
  - S1 registers ReLU'd max of the top pair and ReLU'd max of the bottom pair, plus window index and valid.
  - S2 takes the max of the two S1 values and writes that byte of `tensor_out`. All other bytes hold.
- FSM states:
  - IDLE: reset state. On `start`, clear counters, set `busy`=1 → RUN.
  - RUN: issue window k each enabled cycle. After issuing k=143, stop issuing → DRAIN.
  - DRAIN: wait until S2 writes k=143. At that edge `busy`←0 and `done`←1 → DONE.
  - DONE: hold `tensor_out`. On `start`, `done`←0 and `busy`←1 → RUN (restart).
- `start` while `busy`=1 is ignored.
- `tensor_out` is not cleared on restart; each byte is overwritten when its window is processed.

## Timing
- Reset values: `tensor_out`=0, `busy`=0, `done`=0, FSM=IDLE, counters=0, S1/S2 valid=0.
- Reset is synchronous and overrides `ena`. `iRst`=1 at any edge, including mid-RUN, returns everything to reset values at that edge. No partial result is preserved.
- Edge numbering counts enabled edges only. Edge 0 is the one that samples `start`=1, and `busy`=1 after edge 0.
- Window k inputs are sampled into S1 at edge k+1. Its byte appears on `tensor_out` after edge k+2.
- Window 143 is written at edge 145, and at that same edge `busy`→0 and `done`→1.
- Total latency from `start` to `done` is 145 enabled cycles.
- With `ena`=0, nothing advances and `start` is not sampled. Latency stretches by exactly the number of disabled cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset/idle:
  - Stimulus: assert `iRst` for 2 cycles with random `tensor_in`.
  - Required: `tensor_out`=0, `busy`=0, `done`=0. No change over 20 idle cycles without `start`.
- Ramp map:
  - Stimulus: (r,c) = 0x01+((r*24+c) mod 0x7E), then pulse `start`.
  - Required: each output equals its window's max per the golden model. `done` rises exactly 145 cycles after the `start` edge. Output (0,0) is 0x1A.
- ReLU/sign:
  - Stimulus: all inputs 0x85, except (0,1)=0x80 and (1,1)=0x03.
  - Required: output (0,0)=0x03, all other outputs 0x00.
  - Stimulus: all inputs 0xFF.
  - Required: all outputs 0x00.
- Max ordering:
  - Stimulus: window (11,11) inputs = 0x7F, 0x40, 0x7E, 0x00.
  - Required: output (11,11)=0x7F, written on the final edge (edge 145).
- Enable stall:
  - Stimulus: drop `ena` for 10 cycles at cycle 60 of RUN.
  - Required: `done` at edge 155, results identical to the unstalled run. A `start` pulse while `ena`=0 is ignored.
- Reset mid-run / restart:
  - Stimulus: assert `iRst` at cycle 70.
  - Required: all outputs 0 on the next cycle.
  - Stimulus: `start` while `busy`.
  - Required: ignored, completion time unchanged.
  - Stimulus: `start` in DONE with a new map.
  - Required: `done` drops next cycle; the new results are complete 145 cycles later.
